// File: rtl/fetch_stage_icache.sv
// Fetch stage: PC register plus a direct-mapped instruction cache with a multi-word refill FSM.
// Optional FETCH_PERF_CNT_EN adds saturating hit_cnt/miss_cnt outputs.
module fetch_stage_icache #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned INDEX_W  = 3,
    parameter int unsigned OFFSET_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              pcSrc,
    input  logic              stall,
    output logic              hit,
    output logic [ADDR_W-1:0] pc_inc2,
    output logic [DATA_W-1:0] instruction,
    output logic              out_valid,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);
    localparam int unsigned STEP     = DATA_W / 8;
    localparam int unsigned BYTE_W   = $clog2(STEP);
    localparam int unsigned LINE_LSB = BYTE_W + OFFSET_W;
    localparam int unsigned TAG_LSB  = LINE_LSB + INDEX_W;
    localparam int unsigned TAG_W    = ADDR_W - TAG_LSB;
    localparam int unsigned LINES    = 1 << INDEX_W;
    localparam int unsigned WORDS    = 1 << OFFSET_W;
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((32'd1 << LINE_LSB) - 32'd1);

    typedef enum logic {IDLE, REFILL} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   pc;
    logic [OFFSET_W-1:0] word_cnt;
    logic [LINES-1:0]    valid;
    logic [TAG_W-1:0]    tag_mem  [LINES];
    logic [DATA_W-1:0]   data_mem [LINES][WORDS];
    logic                redirect_pending;
    logic [ADDR_W-1:0]   redirect_target;

    logic [INDEX_W-1:0]  idx;
    logic [OFFSET_W-1:0] off;
    logic [TAG_W-1:0]    tag;
    logic [ADDR_W-1:0]   line_base;
    logic                last_ack;
    logic                fetch_cycle;

    assign idx         = INDEX_W'(pc >> LINE_LSB);
    assign off         = OFFSET_W'(pc >> BYTE_W);
    assign tag         = TAG_W'(pc >> TAG_LSB);
    assign line_base   = pc & LINE_MASK;
    assign hit         = (state == IDLE) && valid[idx] && (tag_mem[idx] == tag);
    assign last_ack    = (state == REFILL) && mem_ack && (&word_cnt);
    assign fetch_cycle = (state == IDLE) && !pcSrc && !stall;

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_addr  = '0;
        if (state == IDLE) begin
            if (fetch_cycle && !hit) state_nxt = REFILL;
        end else begin
            mem_req  = 1'b1;
            mem_addr = line_base + ADDR_W'(32'(word_cnt) * STEP);
            if (last_ack) state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            pc               <= '0;
            valid            <= '0;
            word_cnt         <= '0;
            out_valid        <= 1'b0;
            instruction      <= '0;
            pc_inc2          <= '0;
            redirect_pending <= 1'b0;
            redirect_target  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                if (pcSrc) begin
                    pc        <= branch_target;
                    out_valid <= 1'b0;
                end else if (!stall) begin
                    if (hit) begin
                        instruction <= data_mem[idx][off];
                        pc_inc2     <= pc + ADDR_W'(STEP);
                        pc          <= pc + ADDR_W'(STEP);
                        out_valid   <= 1'b1;
                    end else begin
                        out_valid <= 1'b0;
                        word_cnt  <= '0;
                    end
                end
            end else begin
                out_valid <= 1'b0;
                if (pcSrc) begin
                    redirect_target  <= branch_target;
                    redirect_pending <= 1'b1;
                end
                if (mem_ack) word_cnt <= word_cnt + 1'b1;
                // A redirect arriving on the final ack cycle wins over any older pending one
                if (last_ack) begin
                    valid[idx]       <= 1'b1;
                    redirect_pending <= 1'b0;
                    if (pcSrc)                 pc <= branch_target;
                    else if (redirect_pending) pc <= redirect_target;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == REFILL && mem_ack) begin
            data_mem[idx][word_cnt] <= mem_rdata;
            if (&word_cnt) tag_mem[idx] <= tag;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (fetch_cycle && hit && hit_cnt != '1)    hit_cnt  <= hit_cnt + 32'd1;
            if (fetch_cycle && !hit && miss_cnt != '1)  miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule
